// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues sequential word fetches under a credit limit,
// buffers in-order responses in a small prefetch FIFO and hands {pc, instr} to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  fetch_entry_t   entries [FIFO_DEPTH];
  logic [31:0]    fetch_pc;
  logic [31:0]    resp_pc;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  count;
  logic [CW-1:0]  drop_cnt;

  logic           pop;
  logic           push;
  logic           req_hs;
  logic           credit_ok;
  logic [SW-1:0]  used;
  logic [SW-1:0]  limit;
  logic [IW-1:0]  wr_idx;
  logic [31:0]    target_pc;

  // Credit: outstanding requests plus buffered entries never exceed FIFO_DEPTH
  always_comb begin
    used      = SW'(in_flight) + SW'(count);
    limit     = SW'(FIFO_DEPTH) + SW'(pop);
    credit_ok = used < limit;
  end

  assign out_valid      = (count != '0);
  assign pop            = out_valid & out_ready;
  assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign push           = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign wr_idx         = IW'(count - CW'(pop));
  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign out_pc         = entries[0].pc;
  assign out_instr      = entries[0].instr;

  // Address, occupancy and stale-response bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      in_flight <= '0;
      count     <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_hs) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        count    <= '0;
        drop_cnt <= in_flight - CW'(imem_resp_valid);
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
        count <= count + CW'(push) - CW'(pop);
        if (imem_resp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        entries[IW'(i)] <= '{pc: RESET_PC, instr: 32'h0};
      end
    end else if (!redirect_valid) begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
          entries[IW'(i)] <= entries[IW'(i + 1)];
        end
      end
      if (push) begin
        entries[wr_idx] <= '{pc: resp_pc, instr: imem_resp_data};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  localparam logic [31:0] SALT = 32'hA5A5_0000;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  int          lat    = 1;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] req_addrs [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_instr [$];
  logic        rv_log [64];
  logic [31:0] ra_log [64];
  logic        ov_log [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle starting at a falling edge: drive memory response, log, advance.
  task automatic run_cycle();
    if (pend_due.size() != 0 && pend_due[0] == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_addr[0] ^ SALT;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    if (cyc < 64) begin
      rv_log[cyc] = imem_req_valid;
      ra_log[cyc] = imem_req_addr;
      ov_log[cyc] = out_valid;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      req_addrs.push_back(imem_req_addr);
    end
    if (out_valid && out_ready && !redirect_valid) begin
      pop_pc.push_back(out_pc);
      pop_instr.push_back(out_instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset(input string tag, input int l, input logic rdy);
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = rdy;
    lat             = l;
    #1;
    check_eq({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'h0);
    check_eq({tag, "_rst_out_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_rst_out_pc"}, out_pc, 32'h0);
    check_eq({tag, "_rst_out_instr"}, out_instr, 32'h0);
    check_eq({tag, "_rst_req_addr"}, imem_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    pend_addr.delete();
    pend_due.delete();
    req_addrs.delete();
    pop_pc.delete();
    pop_instr.delete();
    for (int i = 0; i < 64; i++) begin
      rv_log[i] = 1'b0;
      ra_log[i] = 32'hFFFF_FFFF;
      ov_log[i] = 1'b0;
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n = 1'b0;

    // Streaming: 1-cycle memory, decode always ready
    do_reset("t1", 1, 1'b1);
    run_cycles(10);
    check_eq("t1_c0_req_valid", 32'(rv_log[0]), 32'h1);
    check_eq("t1_c0_req_addr", ra_log[0], 32'h0);
    check_eq("t1_c1_out_valid", 32'(ov_log[1]), 32'h0);
    check_eq("t1_c2_out_valid", 32'(ov_log[2]), 32'h1);
    check_eq("t1_npops", 32'(pop_pc.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1_pc%0d", i), pop_pc[i], 32'(4 * i));
      check_eq($sformatf("t1_instr%0d", i), pop_instr[i], 32'(4 * i) ^ SALT);
    end

    // Backpressure from reset: credit caps requests at two
    do_reset("t2", 1, 1'b0);
    run_cycles(8);
    check_eq("t2_nreq", 32'(req_addrs.size()), 32'd2);
    check_eq("t2_req0", req_addrs[0], 32'h0);
    check_eq("t2_req1", req_addrs[1], 32'h4);
    check_eq("t2_c7_req_valid", 32'(rv_log[7]), 32'h0);
    check_eq("t2_c7_out_valid", 32'(ov_log[7]), 32'h1);
    out_ready = 1'b1;
    run_cycles(8);
    check_eq("t2_npops", 32'(pop_pc.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_pc%0d", i), pop_pc[i], 32'(4 * i));
    end

    // Redirect with two slow responses in flight
    do_reset("t3", 3, 1'b1);
    run_cycles(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    run_cycle();
    redirect_valid = 1'b0;
    check_eq("t3_drop_cnt_set", 32'(dut.drop_cnt), 32'd2);
    check_eq("t3_c2_req_valid", 32'(rv_log[2]), 32'h0);
    run_cycles(8);
    check_eq("t3_first_pc", pop_pc[0], 32'h0000_0100);
    check_eq("t3_first_instr", pop_instr[0], 32'h0000_0100 ^ SALT);
    check_eq("t3_second_pc", pop_pc[1], 32'h0000_0104);
    check_eq("t3_drop_cnt_end", 32'(dut.drop_cnt), 32'd0);

    // Redirect coinciding with a response arrival and a pop; unaligned target
    do_reset("t4", 1, 1'b1);
    run_cycles(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    run_cycle();
    redirect_valid = 1'b0;
    run_cycles(4);
    check_eq("t4_c3_out_valid", 32'(ov_log[3]), 32'h1);
    check_eq("t4_c4_out_valid", 32'(ov_log[4]), 32'h0);
    check_eq("t4_c4_req_valid", 32'(rv_log[4]), 32'h1);
    check_eq("t4_c4_req_addr", ra_log[4], 32'h0000_0200);
    check_eq("t4_pc0", pop_pc[0], 32'h0);
    check_eq("t4_pc1", pop_pc[1], 32'h0000_0200);
    check_eq("t4_instr1", pop_instr[1], 32'h0000_0200 ^ SALT);

    // Memory stalls requests for four cycles
    do_reset("t5", 1, 1'b1);
    imem_req_ready = 1'b0;
    run_cycles(4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_c%0d_valid", i), 32'(rv_log[i]), 32'h1);
      check_eq($sformatf("t5_c%0d_addr", i), ra_log[i], 32'h0);
    end
    check_eq("t5_nreq_stall", 32'(req_addrs.size()), 32'd0);
    check_eq("t5_c3_out_valid", 32'(ov_log[3]), 32'h0);
    imem_req_ready = 1'b1;
    run_cycle();
    imem_req_ready = 1'b0;
    run_cycle();
    check_eq("t5_nreq_after", 32'(req_addrs.size()), 32'd1);
    check_eq("t5_req0", req_addrs[0], 32'h0);
    check_eq("t5_c5_addr", ra_log[5], 32'h4);

    // Asynchronous reset with two entries buffered
    do_reset("t6", 1, 1'b0);
    run_cycles(4);
    check_eq("t6_buffered", 32'(ov_log[3]), 32'h1);
    check_eq("t6_count", 32'(dut.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_out_valid", 32'(out_valid), 32'h0);
    check_eq("t6_async_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("t6_async_out_pc", out_pc, 32'h0);
    do_reset("t6b", 1, 1'b1);
    run_cycles(4);
    check_eq("t6_restart_valid", 32'(rv_log[0]), 32'h1);
    check_eq("t6_restart_addr", ra_log[0], 32'h0);
    check_eq("t6_restart_pc", pop_pc[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
